// File: rtl/acc_cpu_core.sv
// Accumulator CPU core: fetch/decode/execute FSM behind a req/ack memory port with wait states.
// Define CPU_CARRY_EN to add the carry/borrow flag and the JC instruction (opcode 7).
module acc_cpu_core #(
  parameter int unsigned    DW       = 16,
  parameter int unsigned    AW       = 8,
  parameter int unsigned    OPW      = 8,
  parameter logic [AW-1:0]  RESET_PC = '0
) (
  input  logic           clk,
  input  logic           rst,
  output logic           mem_req,
  output logic           mem_we,
  output logic [AW-1:0]  mem_addr,
  output logic [DW-1:0]  mem_wdata,
  input  logic           mem_ack,
  input  logic [DW-1:0]  mem_rdata,
  output logic [AW-1:0]  pc,
  output logic [DW-1:0]  acc,
  output logic [OPW-1:0] opcode,
  output logic           zflag,
  output logic           cflag,
  output logic           halted,
  output logic           retire
);

  typedef enum logic [2:0] {
    StFetch,
    StDecode,
    StMemrd,
    StExec,
    StMemwr,
    StHalt
  } state_e;

  localparam logic [OPW-1:0] OpLda = OPW'(1);
  localparam logic [OPW-1:0] OpSta = OPW'(2);
  localparam logic [OPW-1:0] OpAdd = OPW'(3);
  localparam logic [OPW-1:0] OpSub = OPW'(4);
  localparam logic [OPW-1:0] OpJmp = OPW'(5);
  localparam logic [OPW-1:0] OpJz  = OPW'(6);
`ifdef CPU_CARRY_EN
  localparam logic [OPW-1:0] OpJc  = OPW'(7);
`endif
  localparam logic [OPW-1:0] OpHlt = {OPW{1'b1}};

  state_e          state_q, state_d;
  logic [AW-1:0]   pc_q, pc_d;
  logic [AW-1:0]   mar_q, mar_d;
  logic [DW-1:0]   ir_q, ir_d;
  logic [DW-1:0]   acc_q, acc_d;
  logic [DW-1:0]   mdr_q, mdr_d;
  logic [OPW-1:0]  op;
  logic [AW-1:0]   addr;
  logic [DW:0]     add_res;
  logic [DW:0]     sub_res;

  assign op      = ir_q[OPW-1:0];
  assign addr    = ir_q[AW+OPW-1:OPW];
  // One extra bit on each side: top bit is the carry-out or the unsigned borrow.
  assign add_res = {1'b0, acc_q} + {1'b0, mdr_q};
  assign sub_res = {1'b0, acc_q} - {1'b0, mdr_q};

`ifdef CPU_CARRY_EN
  logic c_q, c_d;
`else
  logic unused_carry;
  assign unused_carry = add_res[DW] ^ sub_res[DW];
`endif

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    mar_d   = mar_q;
    ir_d    = ir_q;
    acc_d   = acc_q;
    mdr_d   = mdr_q;
    retire  = 1'b0;
`ifdef CPU_CARRY_EN
    c_d     = c_q;
`endif
    case (state_q)
      StFetch: begin
        if (mem_ack) begin
          ir_d    = mem_rdata;
          pc_d    = pc_q + AW'(1);
          state_d = StDecode;
        end
      end
      StDecode: begin
        if (op == OpHlt) begin
          retire  = 1'b1;
          state_d = StHalt;
        end else begin
          retire  = 1'b1;
          state_d = StFetch;
          case (op)
            OpLda, OpAdd, OpSub: begin
              retire  = 1'b0;
              state_d = StMemrd;
            end
            OpSta: begin
              retire  = 1'b0;
              state_d = StMemwr;
            end
            OpJmp: pc_d = addr;
            OpJz:  if (zflag) pc_d = addr;
`ifdef CPU_CARRY_EN
            OpJc:  if (c_q) pc_d = addr;
`endif
            default: ;
          endcase
        end
      end
      StMemrd: begin
        if (mem_ack) begin
          mdr_d   = mem_rdata;
          state_d = StExec;
        end
      end
      StExec: begin
        case (op)
          OpLda: acc_d = mdr_q;
          OpAdd: begin
            acc_d = add_res[DW-1:0];
`ifdef CPU_CARRY_EN
            c_d   = add_res[DW];
`endif
          end
          OpSub: begin
            acc_d = sub_res[DW-1:0];
`ifdef CPU_CARRY_EN
            c_d   = sub_res[DW];
`endif
          end
          default: ;
        endcase
        retire  = 1'b1;
        state_d = StFetch;
      end
      StMemwr: begin
        if (mem_ack) begin
          retire  = 1'b1;
          state_d = StFetch;
        end
      end
      StHalt:  ;
      default: state_d = StFetch;
    endcase

    // MAR is loaded on entry to a memory state so it stays stable across wait cycles.
    if (state_d == StFetch) begin
      mar_d = pc_d;
    end else if (state_d == StMemrd || state_d == StMemwr) begin
      mar_d = addr;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StFetch;
      pc_q    <= RESET_PC;
      mar_q   <= RESET_PC;
      ir_q    <= '0;
      acc_q   <= '0;
      mdr_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      mar_q   <= mar_d;
      ir_q    <= ir_d;
      acc_q   <= acc_d;
      mdr_q   <= mdr_d;
    end
  end

`ifdef CPU_CARRY_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      c_q <= 1'b0;
    end else begin
      c_q <= c_d;
    end
  end
  assign cflag = c_q;
`else
  assign cflag = 1'b0;
`endif

  // Gated by rst so a pending request is withdrawn as soon as reset asserts.
  assign mem_req   = rst && (state_q == StFetch || state_q == StMemrd || state_q == StMemwr);
  assign mem_we    = rst && (state_q == StMemwr);
  assign mem_addr  = mar_q;
  assign mem_wdata = acc_q;
  assign pc        = pc_q;
  assign acc       = acc_q;
  assign opcode    = op;
  assign zflag     = (acc_q == '0);
  assign halted    = (state_q == StHalt);

endmodule

// File: tb/tb_acc_cpu_core.sv
// Bench for acc_cpu_core: directed programs plus random programs checked against an
// instruction-level model with a req/ack memory that inserts configurable wait states.
module tb_acc_cpu_core;

`ifdef CPU_CARRY_EN
  localparam bit CarryEn = 1'b1;
`else
  localparam bit CarryEn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        mem_req, mem_we, mem_ack;
  logic [7:0]  mem_addr, pc, opcode;
  logic [15:0] mem_wdata, mem_rdata, acc;
  logic        zflag, cflag, halted, retire;

  acc_cpu_core dut (
    .clk      (clk),
    .rst      (rst),
    .mem_req  (mem_req),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_ack  (mem_ack),
    .mem_rdata(mem_rdata),
    .pc       (pc),
    .acc      (acc),
    .opcode   (opcode),
    .zflag    (zflag),
    .cflag    (cflag),
    .halted   (halted),
    .retire   (retire)
  );

  initial forever #5 clk = ~clk;

  logic [15:0] mem [256];
  logic [15:0] img [256];
  logic [15:0] mm  [256];
  int          wait_n = 0;
  bit          nack_wr = 1'b0;
  int          checks = 0;
  int          errors = 0;

  int exp_t [64];
  int exp_acc [64];
  int exp_pc [64];
  int exp_c [64];
  int m_k;
  bit m_halt;
  int dut_ret, last_ret_i, first_ret_i;

  // Memory responder: decides ack mid-cycle so it is stable at the next rising edge.
  initial begin
    int wcnt;
    wcnt = 0;
    mem_ack = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (!rst || !mem_req || (nack_wr && mem_we)) begin
        mem_ack = 1'b0;
        mem_rdata = 16'($urandom);
        if (!rst || !mem_req) wcnt = 0;
      end else if (wcnt < wait_n) begin
        mem_ack = 1'b0;
        mem_rdata = 16'($urandom);
        wcnt++;
      end else begin
        mem_ack = 1'b1;
        mem_rdata = mem[mem_addr];
        if (mem_we) mem[mem_addr] = mem_wdata;
        wcnt = 0;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp_v);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic img_clear();
    for (int i = 0; i < 256; i++) img[i] = 16'h0000;
  endtask

  // Instruction-level reference: one iteration per instruction, latency from the cycle rules.
  task automatic model_run(input int kmax, input int waits);
    int m_acc, m_pc, m_c, t, op, a, opnd, lat, reqs, sum;
    logic [15:0] ir;
    m_acc = 0; m_pc = 0; m_c = 0; t = 0; m_halt = 1'b0; m_k = 0;
    while (m_k < kmax && !m_halt) begin
      ir = mm[m_pc];
      op = int'(ir[7:0]);
      a = int'(ir[15:8]);
      opnd = int'(mm[a]);
      m_pc = (m_pc + 1) % 256;
      lat = 2;
      reqs = 1;
      if (op == 255) begin
        m_halt = 1'b1;
      end else if (op == 1 || op == 3 || op == 4) begin
        lat = 4;
        reqs = 2;
        if (op == 1) m_acc = opnd;
        if (op == 3) begin
          sum = m_acc + opnd;
          m_c = (sum > 65535) ? 1 : 0;
          m_acc = sum % 65536;
        end
        if (op == 4) begin
          m_c = (m_acc < opnd) ? 1 : 0;
          m_acc = (m_acc - opnd + 65536) % 65536;
        end
      end else if (op == 2) begin
        lat = 3;
        reqs = 2;
        mm[a] = 16'(m_acc);
      end else if (op == 5) begin
        m_pc = a;
      end else if (op == 6) begin
        if (m_acc == 0) m_pc = a;
      end else if (op == 7) begin
        if (CarryEn && m_c == 1) m_pc = a;
      end
      t += lat + waits * reqs;
      exp_t[m_k] = t;
      exp_acc[m_k] = m_acc;
      exp_pc[m_k] = m_pc;
      exp_c[m_k] = CarryEn ? m_c : 0;
      m_k++;
    end
  endtask

  // Reset, load img, run until the model's instruction count retires, check each boundary.
  task automatic run_prog(input int kmax, input int waits, input string tag);
    int s, diffs;
    rst = 1'b0;
    nack_wr = 1'b0;
    wait_n = waits;
    #1;
    for (int i = 0; i < 256; i++) begin
      mem[i] = img[i];
      mm[i] = img[i];
    end
    model_run(kmax, waits);
    @(posedge clk);
    #1 rst = 1'b1;
    s = 0;
    dut_ret = 0;
    last_ret_i = -1;
    first_ret_i = -1;
    for (int i = 0; i <= exp_t[m_k-1]; i++) begin
      step();
      if (s < m_k && i == exp_t[s]) begin
        chk($sformatf("%s_acc_%0d", tag, s), 32'(acc), exp_acc[s]);
        chk($sformatf("%s_pc_%0d", tag, s), 32'(pc), exp_pc[s]);
        chk($sformatf("%s_cflag_%0d", tag, s), 32'(cflag), exp_c[s]);
        chk($sformatf("%s_zflag_%0d", tag, s), 32'(zflag), (exp_acc[s] == 0) ? 1 : 0);
        s++;
      end
      if (retire) begin
        if (dut_ret < m_k) chk($sformatf("%s_retire_at_%0d", tag, dut_ret), i, exp_t[dut_ret] - 1);
        if (first_ret_i < 0) first_ret_i = i;
        dut_ret++;
        last_ret_i = i;
      end
    end
    chk({tag, "_retire_count"}, dut_ret, m_k);
    chk({tag, "_halted"}, 32'(halted), 32'(m_halt));
    diffs = 0;
    for (int i = 0; i < 256; i++) if (mem[i] !== mm[i]) diffs++;
    chk({tag, "_mem_diffs"}, diffs, 0);
  endtask

  initial begin
    logic [7:0] ops [12];
    logic [7:0] op, a;
    bool_found_t: begin end
    ops = '{8'd1, 8'd1, 8'd3, 8'd3, 8'd4, 8'd4, 8'd2, 8'd5, 8'd6, 8'd7, 8'h42, 8'h00};

    // Reset state
    #3;
    chk("rst_mem_req", 32'(mem_req), 0);
    chk("rst_retire", 32'(retire), 0);
    chk("rst_halted", 32'(halted), 0);
    chk("rst_zflag", 32'(zflag), 1);
    chk("rst_pc", 32'(pc), 0);
    chk("rst_acc", 32'(acc), 0);
    chk("rst_cflag", 32'(cflag), 0);
    chk("rst_opcode", 32'(opcode), 0);
    chk("rst_mem_addr", 32'(mem_addr), 0);

    // Basic ADD program, zero wait then two wait states per request
    img_clear();
    img[0] = 16'h1001; img[1] = 16'h1103; img[2] = 16'h1202; img[3] = 16'h00FF;
    img[8'h10] = 16'd5; img[8'h11] = 16'd7;
    run_prog(8, 0, "add");
    chk("add_mem12", 32'(mem[8'h12]), 12);
    chk("add_halt_cycle", last_ret_i + 1, 13);
    chk("add_retires", dut_ret, 4);
    run_prog(8, 2, "wait");
    chk("wait_mem12", 32'(mem[8'h12]), 12);
    chk("wait_halt_cycle", last_ret_i + 1, 27);
    chk("wait_acc", 32'(acc), 12);

    // Jumps
    img_clear();
    img[0] = 16'h8001; img[1] = 16'h8004; img[2] = 16'h2006; img[8'h80] = 16'd5;
    run_prog(3, 0, "jz_taken");
    chk("jz_taken_pc", 32'(pc), 32'h20);
    chk("jz_taken_z", 32'(zflag), 1);
    img_clear();
    img[0] = 16'h8001; img[1] = 16'h2006; img[8'h80] = 16'd3;
    run_prog(2, 1, "jz_fall");
    chk("jz_fall_pc", 32'(pc), 2);
    img_clear();
    img[0] = 16'hFF05; img[8'hFF] = 16'h0005;
    run_prog(2, 0, "jmp_ff");
    chk("jmp_ff_pc", 32'(pc), 0);
    img_clear();
    img[0] = 16'hFF05; img[8'hFF] = 16'h0000;
    run_prog(2, 1, "pc_wrap");
    chk("pc_wrap_pc", 32'(pc), 0);

    // Carry out of ADD, then opcode 7
    img_clear();
    img[0] = 16'h8001; img[1] = 16'h8103; img[2] = 16'h3007;
    img[8'h80] = 16'hFFFF; img[8'h81] = 16'd1;
    run_prog(3, 0, "carry");
    chk("carry_acc", 32'(acc), 0);
    chk("carry_z", 32'(zflag), 1);
    chk("carry_c", 32'(cflag), CarryEn ? 1 : 0);
    chk("carry_jc_pc", 32'(pc), CarryEn ? 32'h30 : 32'h3);

    // Unknown opcode then HLT; halt must be absorbing
    img_clear();
    img[0] = 16'h5542; img[1] = 16'h00FF;
    run_prog(4, 0, "nop");
    chk("nop_cycles", first_ret_i + 1, 2);
    for (int i = 0; i < 20; i++) begin
      step();
      chk("halt_no_req", 32'(mem_req), 0);
    end
    chk("halt_pc", 32'(pc), 2);
    chk("halt_acc", 32'(acc), 0);
    chk("halt_still", 32'(halted), 1);

    // Async reset while a store is stalled
    img_clear();
    img[0] = 16'h8001; img[1] = 16'h9002; img[8'h80] = 16'h1234; img[8'h90] = 16'hBEEF;
    rst = 1'b0;
    #1;
    for (int i = 0; i < 256; i++) mem[i] = img[i];
    nack_wr = 1'b1;
    wait_n = 0;
    @(posedge clk);
    #1 rst = 1'b1;
    begin
      int found;
      found = 0;
      for (int i = 0; i < 20 && found == 0; i++) begin
        step();
        if (mem_req && mem_we) found = 1;
      end
      chk("ar_reached_memwr", found, 1);
    end
    step();
    step();
    chk("ar_acc_before", 32'(acc), 32'h1234);
    #1 rst = 1'b0;
    #1;
    chk("ar_req_drop", 32'(mem_req), 0);
    chk("ar_retire", 32'(retire), 0);
    chk("ar_halted", 32'(halted), 0);
    chk("ar_acc", 32'(acc), 0);
    chk("ar_zflag", 32'(zflag), 1);
    chk("ar_pc", 32'(pc), 0);
    step();
    chk("ar_no_write", 32'(mem[8'h90]), 32'hBEEF);
    nack_wr = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    step();
    chk("ar_refetch_req", 32'(mem_req), 1);
    chk("ar_refetch_we", 32'(mem_we), 0);
    chk("ar_refetch_addr", 32'(mem_addr), 0);
    chk("ar_refetch_acc", 32'(acc), 0);

    // Random programs: code in 0x00-0x7F, data in 0x80-0xFF
    for (int run = 0; run < 4; run++) begin
      for (int i = 0; i < 128; i++) begin
        op = ops[$urandom_range(0, 11)];
        if (op >= 8'd1 && op <= 8'd4) a = 8'h80 | 8'($urandom_range(0, 127));
        else if (op >= 8'd5 && op <= 8'd7) a = 8'($urandom_range(0, 63));
        else a = 8'($urandom);
        img[i] = {a, op};
      end
      for (int i = 128; i < 256; i++) begin
        case ($urandom_range(0, 3))
          0: img[i] = 16'h0000;
          1: img[i] = 16'hFFFF;
          default: img[i] = 16'($urandom);
        endcase
      end
      run_prog(30, int'($urandom_range(0, 2)), $sformatf("rand%0d", run));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
